// File: rtl/program_sequencer.sv
// Start/done-controlled instruction sequencer: FETCH/EXEC pacing, stall, abort.
// Optional program repeat is compiled in with `define SEQ_LOOP_EN.
module program_sequencer #(
   parameter int INS_ADDR_WIDTH = 10,
   parameter int LOOP_WIDTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [INS_ADDR_WIDTH-1:0] base_addr,
   input  logic [INS_ADDR_WIDTH-1:0] prog_len,
   input  logic [LOOP_WIDTH-1:0]     loop_count,
   input  logic                      stall,
   input  logic                      abort,
   output logic [INS_ADDR_WIDTH-1:0] pc,
   output logic                      ins_valid,
   output logic                      half_clk,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [INS_ADDR_WIDTH-1:0] ADDR_ONE = 1;

   state_t                      state_q, state_d;
   logic [INS_ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [INS_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [INS_ADDR_WIDTH-1:0]   len_q, len_d;
`ifdef SEQ_LOOP_EN
   localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = 1;
   logic [INS_ADDR_WIDTH-1:0]   base_q, base_d;
   logic [LOOP_WIDTH-1:0]       loop_q, loop_d;
   logic [LOOP_WIDTH-1:0]       rep_q, rep_d;
`else
   logic                        unused_loop_count;
   assign unused_loop_count = ^loop_count;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
`ifdef SEQ_LOOP_EN
         base_q  <= '0;
         loop_q  <= '0;
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
`ifdef SEQ_LOOP_EN
         base_q  <= base_d;
         loop_q  <= loop_d;
         rep_q   <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
`ifdef SEQ_LOOP_EN
      base_d  = base_q;
      loop_d  = loop_q;
      rep_d   = rep_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (prog_len != '0) begin
                  len_d   = prog_len;
                  pc_d    = base_addr;
                  cnt_d   = '0;
`ifdef SEQ_LOOP_EN
                  base_d  = base_addr;
                  loop_d  = loop_count;
                  rep_d   = '0;
`endif
                  state_d = S_FETCH;
               end else begin
                  // Empty program: report completion without issuing anything.
                  state_d = S_DONE;
               end
            end
         end
         S_FETCH: begin
            if (abort)       state_d = S_IDLE;
            else if (!stall) state_d = S_EXEC;
         end
         S_EXEC: begin
            // abort outranks both the advance and the completion decision.
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_q != len_q - ADDR_ONE) begin
               cnt_d   = cnt_q + ADDR_ONE;
               pc_d    = pc_q + ADDR_ONE;
               state_d = S_FETCH;
            end else begin
`ifdef SEQ_LOOP_EN
               if (rep_q < loop_q) begin
                  rep_d   = rep_q + LOOP_ONE;
                  pc_d    = base_q;
                  cnt_d   = '0;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign pc        = pc_q;
   assign ins_valid = (state_q == S_EXEC);
   assign half_clk  = (state_q == S_EXEC);
   assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
   assign done      = (state_q == S_DONE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: per-cycle scoreboard of EXEC cycles and pc,
// plus done/busy tallies checked against hand-computed values.
module tb_program_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [9:0]  prog_len;
   logic [7:0]  loop_count;
   logic        stall;
   logic        abort;
   logic [9:0]  pc;
   logic        ins_valid;
   logic        half_clk;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_q[$];
   int         exp_cyc_q[$];

   int n_done, done_at, busy_cnt;

   program_sequencer #(.INS_ADDR_WIDTH(10), .LOOP_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .prog_len(prog_len), .loop_count(loop_count), .stall(stall), .abort(abort),
      .pc(pc), .ins_valid(ins_valid), .half_clk(half_clk), .busy(busy),
      .done(done), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_exec(input int cyc, input logic [9:0] exp_pc);
      exp_cyc_q.push_back(cyc);
      exp_q.push_back(exp_pc);
   endtask

   // Cycle c is the interval after edge c; edge 0 accepts start.
   task automatic run_prog(input logic [9:0] base, input logic [9:0] len, input logic [7:0] loops,
                           input int stall_from, input int stall_to, input int abort_at,
                           input int restart_at, input int rst_at, input int ncyc);
      logic exp_valid;
      logic [9:0] exp_pc;
      n_done = 0; done_at = 0; busy_cnt = 0;
      start = 1'b1; base_addr = base; prog_len = len; loop_count = loops;
      tick();
      start = 1'b0; base_addr = 10'd100; prog_len = 10'd5; loop_count = 8'd3;
      for (int c = 1; c <= ncyc; c++) begin
         exp_valid = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == c);
         check_eq($sformatf("ins_valid_c%0d", c), {31'd0, ins_valid}, {31'd0, exp_valid});
         check_eq($sformatf("half_clk_c%0d", c), {31'd0, half_clk}, {31'd0, exp_valid});
         if (exp_valid) begin
            void'(exp_cyc_q.pop_front());
            exp_pc = exp_q.pop_front();
            check_eq($sformatf("exec_pc_c%0d", c), {22'd0, pc}, {22'd0, exp_pc});
         end
         if (done) begin
            n_done++;
            done_at = c;
         end
         if (busy) busy_cnt++;
         stall = (c >= stall_from) && (c <= stall_to);
         abort = (c == abort_at);
         rst   = (c == rst_at);
         start = (c == restart_at);
         tick();
         stall = 1'b0; abort = 1'b0; rst = 1'b0; start = 1'b0;
      end
      check_eq("exec_missing", exp_cyc_q.size(), 0);
      exp_cyc_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; prog_len = '0; loop_count = '0;
      stall = 1'b0; abort = 1'b0;
      tick(); tick();
      check_eq("rst_pc", {22'd0, pc}, 0);
      check_eq("rst_ins_valid", {31'd0, ins_valid}, 0);
      check_eq("rst_half_clk", {31'd0, half_clk}, 0);
      check_eq("rst_busy", {31'd0, busy}, 0);
      check_eq("rst_done", {31'd0, done}, 0);
      check_eq("rst_state", {30'd0, state_dbg}, 0);
      rst = 1'b0;
      tick();

      // base 5, len 3: EXEC at 2/4/6, done at 7, busy in 1..6
      expect_exec(2, 10'd5); expect_exec(4, 10'd6); expect_exec(6, 10'd7);
      run_prog(10'd5, 10'd3, 8'd0, 1, 0, 0, 0, 0, 10);
      check_eq("t1_done_cnt", n_done, 1);
      check_eq("t1_done_at", done_at, 7);
      check_eq("t1_busy_cnt", busy_cnt, 6);

      // zero length: immediate done, no issue, pc holds
      run_prog(10'd50, 10'd0, 8'd0, 1, 0, 0, 0, 0, 4);
      check_eq("t2_done_cnt", n_done, 1);
      check_eq("t2_done_at", done_at, 1);
      check_eq("t2_busy_cnt", busy_cnt, 0);
      check_eq("t2_pc_hold", {22'd0, pc}, 7);

      // wrap at top of address space
      expect_exec(2, 10'd1022); expect_exec(4, 10'd1023); expect_exec(6, 10'd0);
      run_prog(10'd1022, 10'd3, 8'd0, 1, 0, 0, 0, 0, 10);
      check_eq("t3_done_cnt", n_done, 1);
      check_eq("t3_done_at", done_at, 7);

      // stall in cycles 3..5 pushes second EXEC to cycle 7
      expect_exec(2, 10'd0); expect_exec(7, 10'd1);
      run_prog(10'd0, 10'd2, 8'd0, 3, 5, 0, 0, 0, 12);
      check_eq("t4_done_cnt", n_done, 1);
      check_eq("t4_done_at", done_at, 8);
      check_eq("t4_busy_cnt", busy_cnt, 7);

      // abort in cycle 3 of a len-4 run
      expect_exec(2, 10'd0);
      run_prog(10'd0, 10'd4, 8'd0, 1, 0, 3, 0, 0, 8);
      check_eq("t5_done_cnt", n_done, 0);
      check_eq("t5_busy_cnt", busy_cnt, 3);
      check_eq("t5_pc_hold", {22'd0, pc}, 1);
      check_eq("t5_state_idle", {30'd0, state_dbg}, 0);

      // start mid-run is ignored
      expect_exec(2, 10'd20); expect_exec(4, 10'd21);
      run_prog(10'd20, 10'd2, 8'd0, 1, 0, 0, 2, 0, 10);
      check_eq("t6_done_cnt", n_done, 1);
      check_eq("t6_done_at", done_at, 5);
      check_eq("t6_busy_cnt", busy_cnt, 4);

      // start in DONE is ignored
      expect_exec(2, 10'd30);
      run_prog(10'd30, 10'd1, 8'd0, 1, 0, 0, 3, 0, 8);
      check_eq("t7_done_cnt", n_done, 1);
      check_eq("t7_done_at", done_at, 3);
      check_eq("t7_busy_cnt", busy_cnt, 2);

      // reset in cycle 3 clears everything, no done
      expect_exec(2, 10'd40);
      run_prog(10'd40, 10'd4, 8'd0, 1, 0, 0, 0, 3, 8);
      check_eq("t8_done_cnt", n_done, 0);
      check_eq("t8_busy_cnt", busy_cnt, 3);
      check_eq("t8_pc_zero", {22'd0, pc}, 0);

      // repeat: loop_count=1 runs twice only with the feature built in
`ifdef SEQ_LOOP_EN
      expect_exec(2, 10'd8); expect_exec(4, 10'd9); expect_exec(6, 10'd8); expect_exec(8, 10'd9);
      run_prog(10'd8, 10'd2, 8'd1, 1, 0, 0, 0, 0, 12);
      check_eq("t9_done_cnt", n_done, 1);
      check_eq("t9_done_at", done_at, 9);
`else
      expect_exec(2, 10'd8); expect_exec(4, 10'd9);
      run_prog(10'd8, 10'd2, 8'd1, 1, 0, 0, 0, 0, 12);
      check_eq("t9_done_cnt", n_done, 1);
      check_eq("t9_done_at", done_at, 5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Replaces the free-running PC with a start/done-controlled instruction sequencer for the SIMD core.
- Walks instruction memory from a programmable base address for a programmable length.
- Paces issue as two cycles per instruction: a FETCH cycle for BRAM read latency, then an EXEC cycle.
- Drives the decoder's pc input and an instruction-valid qualifier that gates decoder write_en and dot_ctrl at the top level; supports stall, abort and (optionally) program repeat.

Parameters:
- INS_ADDR_WIDTH, 10, instruction memory address width and width of pc, base_addr and prog_len.
- LOOP_WIDTH, 8, width of the repeat counter (used only with SEQ_LOOP_EN).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle request to run a program; sampled only in IDLE.
- base_addr  input  INS_ADDR_WIDTH  first instruction address; latched on accepted start.
- prog_len  input  INS_ADDR_WIDTH  number of instructions to issue; latched on accepted start.
- loop_count  input  LOOP_WIDTH  extra repetitions of the program; latched on start, ignored without SEQ_LOOP_EN.
- stall  input  1  holds the sequencer in FETCH while high.
- abort  input  1  terminates the run immediately.
- pc  output  INS_ADDR_WIDTH  instruction memory address.
- ins_valid  output  1  high while the instruction at pc is to be executed.
- half_clk  output  1  equal to ins_valid; drop-in phase strobe for existing logic.
- busy  output  1  high in FETCH and EXEC.
- done  output  1  single-cycle completion pulse.

Behaviour:
- States: IDLE, FETCH, EXEC, DONE. All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Reset (rst=1 at posedge), regardless of current state:
  - state=IDLE; pc=0; instruction count=0; repeat count=0.
  - ins_valid=0, half_clk=0, busy=0, done=0.
  - Reset mid-run discards the run and produces no done.
- IDLE:
  - start=1 and prog_len!=0: latch base_addr, prog_len, loop_count; pc<=base_addr; count<=0; go to FETCH.
  - start=1 and prog_len==0: go to DONE; no instruction is issued.
  - start=0: remain in IDLE; pc holds its last value.
- FETCH:
  - ins_valid=0, busy=1.
  - stall=1: remain in FETCH; pc holds.
  - stall=0: go to EXEC.
- EXEC:
  - ins_valid=1, half_clk=1, busy=1, for exactly one cycle. Instruction data from memory is valid in this cycle (1-cycle BRAM latency).
  - count<latched_len-1: count++, pc<=pc+1, go to FETCH.
  - count==latched_len-1: go to DONE, or repeat per SEQ_LOOP_EN.
  - stall has no effect in EXEC.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - A start arriving in DONE is ignored.
- pc arithmetic is modulo 2^INS_ADDR_WIDTH: 2^INS_ADDR_WIDTH-1 wraps to 0 with no error.
- start while busy or in DONE is ignored; latched parameters never change mid-run.
- abort=1 in FETCH or EXEC:
  - Next state IDLE, ins_valid=0 from the next cycle, no done pulse, pc holds.
  - abort has priority over stall and over completion.
  - abort in IDLE or DONE is ignored.
- Issue timing: with no stall, start accepted at edge 0 gives EXEC at cycles 2, 4, …, 2N and the done pulse at cycle 2N+1.

Optional Feature:
- SEQ_LOOP_EN defined:
  - On the last EXEC with repeat count < latched loop_count: repeat count++, pc<=latched base_addr, count<=0, go to FETCH.
  - Total issued instructions = prog_len*(loop_count+1).
- SEQ_LOOP_EN undefined: loop_count is ignored and the program runs exactly once.

Test Plan:
- base_addr=5, prog_len=3, no stall: ins_valid in cycles 2/4/6 with pc=5/6/7; done=1 in cycle 7 only; busy=1 in cycles 1–6.
- prog_len=0, start: done=1 in cycle 1; ins_valid never asserted; pc unchanged.
- base_addr=1022, prog_len=3, INS_ADDR_WIDTH=10: EXEC pc sequence 1022, 1023, 0; done follows.
- stall=1 for cycles 3–5 during a len=2 run from 0: second EXEC (pc=1) moves from cycle 4 to cycle 7; done in cycle 8.
- abort in cycle 3 of a len=4 run: ins_valid=0 from cycle 4; no done pulse; back in IDLE. Separately, start in cycle 2 of a run is ignored. Separately, rst in cycle 3 gives all outputs 0 at the next edge.
- SEQ_LOOP_EN defined, base_addr=8, prog_len=2, loop_count=1: EXEC pc sequence 8, 9, 8, 9; exactly one done, in cycle 9.
